// File: rtl/alu_acc_seq_if.sv
// Command/result bundle for alu_acc_seq.
// master drives commands, slave is the ALU.
interface alu_acc_seq_if #(
  parameter int WIDTH = 8
);
  logic             on;
  logic             start;
  logic [2:0]       in_sel;
  logic [6:0]       op_sel;
  logic [WIDTH-1:0] num1;
  logic [WIDTH-1:0] num2;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       state;

  modport master (
    output on, start, in_sel, op_sel,
    output num1, num2,
    input  out, busy, done, err, state
  );

  modport slave (
    input  on, start, in_sel, op_sel,
    input  num1, num2,
    output out, busy, done, err, state
  );
endinterface

// File: rtl/alu_acc_seq.sv
// Sequential accumulator ALU with serial multiplier and sticky error.
// Define ALU_SAT_EN to saturate instead of wrap on overflow.
module alu_acc_seq #(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  alu_acc_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    OFF   = 2'b00,
    READY = 2'b01,
    RUN   = 2'b10,
    ERR   = 2'b11
  } state_t;

  state_t             state_q, state_n;
  logic [WIDTH-1:0]   out_q, out_n;
  logic [WIDTH-1:0]   a_q, a_n;
  logic [WIDTH-1:0]   b_q, b_n;
  logic [6:0]         op_q, op_n;
  logic               err_q, err_n;
  logic               done_q, done_n;
  logic [CW-1:0]      cnt_q, cnt_n;
  logic [2*WIDTH-1:0] prod_q, prod_n;
  logic [2*WIDTH-1:0] mcand_q, mcand_n;
  logic [2*WIDTH-1:0] psum;
  logic [WIDTH:0]     sum, diff;
  logic [WIDTH-1:0]   res, a_sel;
  logic               ovf, op_hot, cmd_ok;

  assign op_hot = (bus.op_sel != 7'd0) &&
    ((bus.op_sel & (bus.op_sel - 7'd1)) == 7'd0);
  assign cmd_ok = (|bus.in_sel[1:0]) && op_hot;
  assign a_sel  = bus.in_sel[1] ? bus.num1 : out_q;

  // b_q doubles as the multiplier shift register during MUL
  always_comb begin
    sum  = {1'b0, a_q} + {1'b0, b_q};
    diff = {1'b0, a_q} - {1'b0, b_q};
    psum = prod_q + (b_q[0] ? mcand_q : '0);
    res  = '0;
    ovf  = 1'b0;
    unique case (1'b1)
      op_q[6]: begin
        res = psum[WIDTH-1:0];
        ovf = |psum[2*WIDTH-1:WIDTH];
      end
      op_q[5]: begin
        res = diff[WIDTH-1:0];
        ovf = diff[WIDTH];
      end
      op_q[4]: begin
        res = sum[WIDTH-1:0];
        ovf = sum[WIDTH];
      end
      op_q[3]: res = ~a_q;
      op_q[2]: res = a_q ^ b_q;
      op_q[1]: res = a_q | b_q;
      op_q[0]: res = a_q & b_q;
      default: res = '0;
    endcase
`ifdef ALU_SAT_EN
    if (ovf) res = op_q[5] ? '0 : '1;
`else
    res = res;
`endif
  end

  always_comb begin
    state_n = state_q;
    out_n   = out_q;
    a_n     = a_q;
    b_n     = b_q;
    op_n    = op_q;
    err_n   = err_q;
    done_n  = 1'b0;
    cnt_n   = cnt_q;
    prod_n  = prod_q;
    mcand_n = mcand_q;
    unique case (state_q)
      OFF: begin
        if (bus.on) state_n = READY;
      end
      READY: begin
        if (!bus.on) begin
          state_n = OFF;
          out_n   = '0;
          err_n   = 1'b0;
        end else if (bus.start) begin
          if (bus.in_sel[2]) begin
            out_n  = '0;
            err_n  = 1'b0;
            done_n = 1'b1;
          end else if (cmd_ok) begin
            a_n     = a_sel;
            b_n     = bus.num2;
            op_n    = bus.op_sel;
            err_n   = 1'b0;
            cnt_n   = '0;
            prod_n  = '0;
            mcand_n = {{WIDTH{1'b0}}, a_sel};
            state_n = RUN;
          end else begin
            err_n   = 1'b1;
            state_n = ERR;
          end
        end
      end
      RUN: begin
        if (!bus.on) begin
          state_n = OFF;
          out_n   = '0;
          err_n   = 1'b0;
        end else if (op_q[6] &&
                     cnt_q != CW'(WIDTH-1)) begin
          prod_n  = psum;
          mcand_n = mcand_q << 1;
          b_n     = b_q >> 1;
          cnt_n   = cnt_q + CW'(1);
        end else begin
          out_n   = res;
          done_n  = 1'b1;
          err_n   = ovf;
          state_n = ovf ? ERR : READY;
        end
      end
      ERR: begin
        if (!bus.on) begin
          state_n = OFF;
          out_n   = '0;
          err_n   = 1'b0;
        end else begin
          state_n = READY;
        end
      end
      default: state_n = OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= OFF;
      out_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
      mcand_q <= '0;
    end else begin
      state_q <= state_n;
      out_q   <= out_n;
      a_q     <= a_n;
      b_q     <= b_n;
      op_q    <= op_n;
      err_q   <= err_n;
      done_q  <= done_n;
      cnt_q   <= cnt_n;
      prod_q  <= prod_n;
      mcand_q <= mcand_n;
    end
  end

  assign bus.out   = out_q;
  assign bus.busy  = (state_q == RUN);
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.state = state_q;
endmodule

// File: tb/tb_alu_acc_seq.sv
// Scoreboard bench for alu_acc_seq with a
// arithmetic reference model and random commands.
module tb_alu_acc_seq;
  localparam int W = 8;
  localparam logic [W-1:0] MASK = '1;
  localparam logic [6:0] MUL = 7'b1000000;
  localparam logic [6:0] SUB = 7'b0100000;
  localparam logic [6:0] ADD = 7'b0010000;
  localparam logic [6:0] NOT = 7'b0001000;
  localparam logic [6:0] XOR = 7'b0000100;
  localparam logic [6:0] OR  = 7'b0000010;
  localparam logic [6:0] AND = 7'b0000001;

  typedef struct packed {
    logic [W-1:0] out;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_acc_seq_if #(.WIDTH(W)) bus();

  alu_acc_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t         exp_q[$];
  int           checks   = 0;
  int           failures = 0;
  logic [W-1:0] acc;
  logic         merr;
  logic         exp_to_err;
  int           exp_lat;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst && bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got out=%0d expected no done",
                 bus.out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_out", 32'(bus.out), 32'(e.out));
        check("done_err", 32'(bus.err), 32'(e.err));
      end
    end
  end

  task automatic predict(input logic [2:0] is,
                         input logic [6:0] os,
                         input logic [W-1:0] n1,
                         input logic [W-1:0] n2);
    longint a, b, full;
    logic ovf;
    logic [W-1:0] r;
    exp_t e;
    if (is[2]) begin
      acc = '0;
      merr = 1'b0;
      exp_to_err = 1'b0;
      exp_lat = 0;
      e.out = '0;
      e.err = 1'b0;
      exp_q.push_back(e);
    end else if (is[1:0] != 2'b00 && $countones(os) == 1) begin
      a = is[1] ? longint'(n1) : longint'(acc);
      b = longint'(n2);
      if (os[6])      full = a * b;
      else if (os[5]) full = a - b;
      else if (os[4]) full = a + b;
      else if (os[3]) full = ~a & longint'(MASK);
      else if (os[2]) full = a ^ b;
      else if (os[1]) full = a | b;
      else            full = a & b;
      ovf = (full < 0) || (full > longint'(MASK));
      r = full[W-1:0];
`ifdef ALU_SAT_EN
      if (ovf) r = os[5] ? '0 : MASK;
`endif
      acc = r;
      merr = ovf;
      exp_to_err = ovf;
      exp_lat = os[6] ? W : 1;
      e.out = r;
      e.err = ovf;
      exp_q.push_back(e);
    end else begin
      merr = 1'b1;
      exp_to_err = 1'b1;
      exp_lat = 0;
    end
  endtask

  task automatic accept(input logic [2:0] is,
                        input logic [6:0] os,
                        input logic [W-1:0] n1,
                        input logic [W-1:0] n2);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.in_sel = is;
    bus.op_sel = os;
    bus.num1   = n1;
    bus.num2   = n2;
    predict(is, os, n1, n2);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic finish_cmd(input string tag);
    int cyc;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_busy_cycles"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_state"}, 32'(bus.state),
          exp_to_err ? 32'd3 : 32'd1);
    check({tag, "_out"}, 32'(bus.out), 32'(acc));
    check({tag, "_err"}, 32'(bus.err), 32'(merr));
    if (exp_to_err) begin
      @(posedge clk);
      #1;
      check({tag, "_err_exit"}, 32'(bus.state), 32'd1);
      check({tag, "_err_sticky"}, 32'(bus.err), 32'd1);
    end
  endtask

  task automatic run(input string tag,
                     input logic [2:0] is,
                     input logic [6:0] os,
                     input logic [W-1:0] n1,
                     input logic [W-1:0] n2);
    accept(is, os, n1, n2);
    finish_cmd(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] is;
    logic [6:0] os;
    int pick;
    bus.on     = 1'b0;
    bus.start  = 1'b0;
    bus.in_sel = '0;
    bus.op_sel = '0;
    bus.num1   = '0;
    bus.num2   = '0;
    acc  = '0;
    merr = 1'b0;
    exp_to_err = 1'b0;
    exp_lat = 0;
    #12;
    check("rst_out",   32'(bus.out),   32'd0);
    check("rst_busy",  32'(bus.busy),  32'd0);
    check("rst_done",  32'(bus.done),  32'd0);
    check("rst_err",   32'(bus.err),   32'd0);
    check("rst_state", 32'(bus.state), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bus.on = 1'b1;
    @(posedge clk);
    #1;
    check("power_on", 32'(bus.state), 32'd1);

    run("mul3x2",  3'b010, MUL, 8'd3,  8'd2);
    run("mul_ovf", 3'b010, MUL, 8'd87, 8'd26);
    run("sub_brw", 3'b010, SUB, 8'd2,  8'd4);
    run("add11",   3'b010, ADD, 8'd1,  8'd1);
    run("ld_add",  3'b010, ADD, 8'd4,  8'd8);
    run("ps_add",  3'b001, ADD, 8'd0,  8'd10);
    run("ps_mul",  3'b001, MUL, 8'd0,  8'd2);
    run("clear",   3'b100, ADD, 8'd0,  8'd0);
    run("xor",     3'b010, XOR, 8'd50, 8'd25);
    run("or",      3'b010, OR,  8'd50, 8'd25);
    run("and",     3'b010, AND, 8'd50, 8'd25);
    run("not",     3'b010, NOT, 8'd129, 8'd7);
    run("bad_op",  3'b010, 7'b0000011, 8'd1, 8'd1);
    run("bad_sel", 3'b000, ADD, 8'd1, 8'd1);

    // power drop during a multiply
    accept(3'b010, MUL, 8'd9, 8'd9);
    void'(exp_q.pop_back());
    repeat (2) @(posedge clk);
    #1;
    bus.on = 1'b0;
    @(posedge clk);
    #1;
    acc = '0;
    merr = 1'b0;
    check("abort_state", 32'(bus.state), 32'd0);
    check("abort_out",   32'(bus.out),   32'd0);
    check("abort_busy",  32'(bus.busy),  32'd0);
    check("abort_err",   32'(bus.err),   32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("off_hold", 32'(bus.state), 32'd0);
    bus.on = 1'b1;
    @(posedge clk);
    #1;
    check("off_ready", 32'(bus.state), 32'd1);

    // asynchronous reset during a multiply
    accept(3'b010, MUL, 8'd200, 8'd3);
    void'(exp_q.pop_back());
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("arst_out",   32'(bus.out),   32'd0);
    check("arst_busy",  32'(bus.busy),  32'd0);
    check("arst_done",  32'(bus.done),  32'd0);
    check("arst_err",   32'(bus.err),   32'd0);
    check("arst_state", 32'(bus.state), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    acc = '0;
    merr = 1'b0;
    @(posedge clk);
    #1;
    check("arst_ready", 32'(bus.state), 32'd1);

    // start held while busy must be ignored
    accept(3'b010, MUL, 8'd5, 8'd7);
    fork
      finish_cmd("busy_ign");
      begin
        repeat (3) begin
          @(negedge clk);
          bus.start  = 1'b1;
          bus.in_sel = 3'b010;
          bus.op_sel = ADD;
          bus.num1   = 8'd1;
          bus.num2   = 8'd1;
        end
        @(negedge clk);
        bus.start = 1'b0;
      end
    join

    for (int i = 0; i < 40; i++) begin
      pick = $urandom_range(0, 9);
      if (pick == 0)      is = 3'b000;
      else if (pick == 1) is = 3'b100;
      else if (pick < 5)  is = 3'b001;
      else if (pick < 8)  is = 3'b010;
      else                is = 3'b011;
      if ($urandom_range(0, 7) == 0)
        os = 7'($urandom_range(0, 127));
      else
        os = 7'(1 << $urandom_range(0, 6));
      run("rand", is, os,
          W'($urandom_range(0, 255)),
          W'($urandom_range(0, 255)));
    end

    repeat (2) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule
